// File: rtl/mem_line_ctrl_pkg.sv
// mem_line_ctrl_pkg
// Definitions shared by the memory-side line responder and the cache
// controller that talks to it. Contents:
//   - line geometry (words per line, width of the beat/word counter)
//   - FSM state encoding of the responder
//   - encoding of the rdwr request field
//   - beat_word(): word index of a beat inside a line, wrapping mod line size
package mem_line_ctrl_pkg;

    localparam int WORDS_PER_LINE = 4;
    localparam int BEAT_CNT_W     = 2;
    localparam int STATE_W        = 3;

    localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [STATE_W-1:0] ST_WAIT  = 3'd1;
    localparam logic [STATE_W-1:0] ST_BEAT  = 3'd2;
    localparam logic [STATE_W-1:0] ST_GAP   = 3'd3;
    localparam logic [STATE_W-1:0] ST_WRITE = 3'd4;
    localparam logic [STATE_W-1:0] ST_DONE  = 3'd5;

    localparam logic RDWR_READ  = 1'b0;
    localparam logic RDWR_WRITE = 1'b1;

    // Word index of beat number 'beat' when the burst starts at word 'w0'.
    // The counter width equals log2(WORDS_PER_LINE), so the add wraps for free.
    function automatic logic [BEAT_CNT_W-1:0] beat_word(
        input logic [BEAT_CNT_W-1:0] w0,
        input logic [BEAT_CNT_W-1:0] beat
    );
        return w0 + beat;
    endfunction

endpackage

// File: rtl/mem_line_array.sv
// mem_line_array
// Synchronous single-port word RAM backing the line responder.
// One access per cycle: either a write (we_i) or a read (re_i). Read data
// appears in the cycle after the read is issued and then holds until the
// next read. The data array itself is never reset; only the read register is.
// Ports:
//   clk, rst   clock, asynchronous active-high reset (read register only)
//   we_i       write enable
//   re_i       read enable
//   addr_i     word address
//   wdata_i    write data
//   rdata_o    registered read data
module mem_line_array
    import mem_line_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [0:(1 << ADDR_WIDTH)-1];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Array write port; contents survive reset on purpose.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // Read register: cleared by reset, updated only on a read, otherwise holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_line_ctrl.sv
// mem_line_ctrl
// Memory-side responder sitting directly below the cache controller.
// Serves 4-beat read line fills (one ack per word, one idle cycle between
// beats) and 128-bit line writebacks (4 word writes, then one ack pulse).
// The first beat/write happens LATENCY cycles after the accept edge.
// Optional feature (macro MEM_LINE_CTRL_CRITICAL_WORD_FIRST_EN): read beats
// start at the requested word and wrap; otherwise they always run 0..3.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   req_cc2mem     request level, held by the controller until done
//   adr_cc2mem     byte address of requested word/line
//   rdwr_cc2mem    0 = read line fill, 1 = line writeback
//   dat_cc2mem     writeback line, word i at bits [32i+31:32i]
//   ack_mem2cc     beat / writeback-completion strobe
//   dat_mem2cc     read beat data (holds last beat between beats)
//   word_mem2cc    word index of the current beat (holds likewise)
//   busy_mem       high from accept until back in IDLE
module mem_line_ctrl
    import mem_line_ctrl_pkg::*;
#(
    parameter int ADR_WIDTH      = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int WORD_OFFSET    = 2,
    parameter int DATAMEM_WIDTH  = 128,
    parameter int MEM_DEPTH_LOG2 = 10,
    parameter int LATENCY        = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_cc2mem,
    input  logic [ADR_WIDTH-1:0]     adr_cc2mem,
    input  logic                     rdwr_cc2mem,
    input  logic [DATAMEM_WIDTH-1:0] dat_cc2mem,
    output logic                     ack_mem2cc,
    output logic [DATA_WIDTH-1:0]    dat_mem2cc,
    output logic [WORD_OFFSET-1:0]   word_mem2cc,
    output logic                     busy_mem
);

    localparam int LINE_AW = MEM_DEPTH_LOG2 - WORD_OFFSET;
    localparam int CNT_W   = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    logic [STATE_W-1:0]        state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [BEAT_CNT_W-1:0]     beat_q, beat_d;
    logic                      wr_ack_q, wr_ack_d;
    logic [LINE_AW-1:0]        line_q, line_d;
    logic [BEAT_CNT_W-1:0]     w0_q, w0_d;
    logic                      rdwr_q, rdwr_d;
    logic [DATAMEM_WIDTH-1:0]  wline_q, wline_d;
    logic                      ack_q, ack_d;
    logic [WORD_OFFSET-1:0]    word_q, word_d;
    logic                      busy_q, busy_d;

    logic                      first_s;
    logic                      ram_we_s;
    logic                      ram_re_s;
    logic [MEM_DEPTH_LOG2-1:0] ram_addr_s;
    logic [DATA_WIDTH-1:0]     ram_wdata_s;
    logic [DATA_WIDTH-1:0]     ram_rdata_s;
    logic [LINE_AW-1:0]        adr_line_s;
    logic [BEAT_CNT_W-1:0]     adr_w0_s;
    logic [BEAT_CNT_W-1:0]     nxt_word_s;
    logic                      unused_s;

    // Upper address bits alias onto the array; byte offset is meaningless here.
    assign adr_line_s = adr_cc2mem[MEM_DEPTH_LOG2+1:WORD_OFFSET+2];
`ifdef MEM_LINE_CTRL_CRITICAL_WORD_FIRST_EN
    assign adr_w0_s = adr_cc2mem[WORD_OFFSET+1:2];
`else
    assign adr_w0_s = {BEAT_CNT_W{1'b0}};
`endif
    assign unused_s = ^{adr_cc2mem[ADR_WIDTH-1:MEM_DEPTH_LOG2+2], adr_cc2mem[WORD_OFFSET+1:0]};

    assign nxt_word_s = beat_word(w0_q, beat_q + 2'd1);

    // Next-state logic: FSM, request latching, RAM access and output strobes.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        beat_d      = beat_q;
        wr_ack_d    = wr_ack_q;
        line_d      = line_q;
        w0_d        = w0_q;
        rdwr_d      = rdwr_q;
        wline_d     = wline_q;
        ack_d       = 1'b0;
        word_d      = word_q;
        busy_d      = busy_q;
        first_s     = 1'b0;
        ram_we_s    = 1'b0;
        ram_re_s    = 1'b0;
        ram_addr_s  = {line_q, beat_q};
        ram_wdata_s = wline_q[int'(beat_q) * DATA_WIDTH +: DATA_WIDTH];

        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (req_cc2mem) begin
                    line_d  = adr_line_s;
                    w0_d    = adr_w0_s;
                    rdwr_d  = rdwr_cc2mem;
                    wline_d = dat_cc2mem;
                    busy_d  = 1'b1;
                    if (LATENCY == 1) begin
                        first_s = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_W'(LATENCY - 1);
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                // Leaving on the edge that takes the counter to zero keeps
                // the first beat exactly LATENCY cycles after accept.
                if (cnt_q == CNT_W'(1)) begin
                    first_s = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_BEAT: begin
                if (beat_q == 2'd3) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                // Read is issued here so the RAM output lands with the ack.
                state_d    = ST_BEAT;
                beat_d     = beat_q + 2'd1;
                ram_re_s   = 1'b1;
                ram_addr_s = {line_q, nxt_word_s};
                word_d     = nxt_word_s;
                ack_d      = 1'b1;
            end
            ST_WRITE: begin
                if (wr_ack_q) begin
                    // Completion-pulse cycle is over; nothing left to write.
                    state_d  = ST_DONE;
                    wr_ack_d = 1'b0;
                end else begin
                    ram_we_s = 1'b1;
                    if (beat_q == 2'd3) begin
                        wr_ack_d = 1'b1;
                        ack_d    = 1'b1;
                    end else begin
                        beat_d = beat_q + 2'd1;
                    end
                end
            end
            ST_DONE: begin
                if (!req_cc2mem) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // Entry into the data phase, shared by IDLE (LATENCY=1) and WAIT.
        // line_d/w0_d/rdwr_d hold the values that are (or are being) latched.
        if (first_s) begin
            beat_d   = {BEAT_CNT_W{1'b0}};
            wr_ack_d = 1'b0;
            if (rdwr_d == RDWR_READ) begin
                state_d    = ST_BEAT;
                ram_re_s   = 1'b1;
                ram_addr_s = {line_d, w0_d};
                word_d     = w0_d;
                ack_d      = 1'b1;
            end else begin
                state_d = ST_WRITE;
            end
        end else begin
            beat_d = beat_d;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            beat_q   <= '0;
            wr_ack_q <= 1'b0;
            line_q   <= '0;
            w0_q     <= '0;
            rdwr_q   <= RDWR_READ;
            wline_q  <= '0;
            ack_q    <= 1'b0;
            word_q   <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            beat_q   <= beat_d;
            wr_ack_q <= wr_ack_d;
            line_q   <= line_d;
            w0_q     <= w0_d;
            rdwr_q   <= rdwr_d;
            wline_q  <= wline_d;
            ack_q    <= ack_d;
            word_q   <= word_d;
            busy_q   <= busy_d;
        end
    end

    mem_line_array #(
        .ADDR_WIDTH (MEM_DEPTH_LOG2),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .we_i    (ram_we_s),
        .re_i    (ram_re_s),
        .addr_i  (ram_addr_s),
        .wdata_i (ram_wdata_s),
        .rdata_o (ram_rdata_s)
    );

    assign ack_mem2cc  = ack_q;
    assign dat_mem2cc  = ram_rdata_s;
    assign word_mem2cc = word_q;
    assign busy_mem    = busy_q;

endmodule

// File: tb/tb_mem_line_ctrl.sv
// tb_mem_line_ctrl
// Two responders share one reset: u_dut0 with LATENCY=2, u_dut1 with LATENCY=1.
// A word-array model plus the beat/ack timing rules gives every expectation.
module tb_mem_line_ctrl;

    localparam int LAT0 = 2;
    localparam int LAT1 = 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         req  [2];
    logic [31:0]  adr  [2];
    logic         rdwr [2];
    logic [127:0] wdat [2];
    logic         ack  [2];
    logic [31:0]  dat  [2];
    logic [1:0]   word [2];
    logic         busy [2];

    logic [31:0]  model_mem [2][1024];
    logic [31:0]  hold_dat  [2];
    logic [1:0]   hold_word [2];
    int           pool [8];
    int           n_cmp;
    int           n_fail;

    always #5 clk = ~clk;

    mem_line_ctrl #(.LATENCY(LAT0)) u_dut0 (
        .clk(clk), .rst(rst), .req_cc2mem(req[0]), .adr_cc2mem(adr[0]),
        .rdwr_cc2mem(rdwr[0]), .dat_cc2mem(wdat[0]), .ack_mem2cc(ack[0]),
        .dat_mem2cc(dat[0]), .word_mem2cc(word[0]), .busy_mem(busy[0])
    );

    mem_line_ctrl #(.LATENCY(LAT1)) u_dut1 (
        .clk(clk), .rst(rst), .req_cc2mem(req[1]), .adr_cc2mem(adr[1]),
        .rdwr_cc2mem(rdwr[1]), .dat_cc2mem(wdat[1]), .ack_mem2cc(ack[1]),
        .dat_mem2cc(dat[1]), .word_mem2cc(word[1]), .busy_mem(busy[1])
    );

    function automatic int lat_of(input int d);
        return (d == 0) ? LAT0 : LAT1;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outputs(input int d, input string tag, input logic exp_ack, input logic exp_busy);
        chk($sformatf("%s ack d%0d", tag, d), 128'(ack[d]), 128'(exp_ack));
        chk($sformatf("%s dat d%0d", tag, d), 128'(dat[d]), 128'(hold_dat[d]));
        chk($sformatf("%s word d%0d", tag, d), 128'(word[d]), 128'(hold_word[d]));
        chk($sformatf("%s busy d%0d", tag, d), 128'(busy[d]), 128'(exp_busy));
    endtask

    // One full request: must be entered at a negedge with the DUT idle.
    // hold: extra cycles req stays high once DONE is reached.
    // drop_at: cycle at which req falls early (0 = never).
    // abort_at: cycle after whose checks rst is pulsed (0 = never).
    task automatic do_txn(input int d, input logic rw, input logic [31:0] a,
                          input logic [127:0] line, input int hold,
                          input int drop_at, input int abort_at);
        int   l;
        int   done_c;
        int   base;
        int   w0;
        int   k;
        bit   released;
        bit   finished;
        logic exp_ack;
        l    = lat_of(d);
        base = int'(a[11:4]) * 4;
`ifdef MEM_LINE_CTRL_CRITICAL_WORD_FIRST_EN
        w0 = int'(a[3:2]);
`else
        w0 = 0;
`endif
        if (rw) begin
            for (int i = 0; i < 4; i++) model_mem[d][base + i] = line[32*i +: 32];
        end
        done_c   = rw ? l + 5 : l + 7;
        released = 1'b0;
        finished = 1'b0;
        req[d]   = 1'b1;
        adr[d]   = a;
        rdwr[d]  = rw;
        wdat[d]  = line;
        for (int c = 1; c <= done_c + hold + 4 && !finished; c++) begin
            @(negedge clk);
            if (c == 1) begin
                adr[d]  = $urandom;
                rdwr[d] = 1'($urandom_range(1, 0));
                wdat[d] = {$urandom, $urandom, $urandom, $urandom};
            end
            if (rw) exp_ack = (c == l + 4);
            else    exp_ack = (c >= l) && (c <= l + 6) && (((c - l) % 2) == 0);
            if (exp_ack && !rw) begin
                k = (c - l) / 2;
                hold_word[d] = 2'((w0 + k) % 4);
                hold_dat[d]  = model_mem[d][base + ((w0 + k) % 4)];
            end
            chk_outputs(d, $sformatf("%s a=%0h c%0d", rw ? "wr" : "rd", a, c), exp_ack, !released);
            if (released) begin
                finished = 1'b1;
            end else if (c == abort_at) begin
                #1 rst = 1'b1;
                #1;
                hold_dat[0] = '0; hold_dat[1] = '0;
                hold_word[0] = '0; hold_word[1] = '0;
                chk_outputs(d, "async_rst", 1'b0, 1'b0);
                req[d] = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                finished = 1'b1;
            end else begin
                if ((drop_at != 0 && c >= drop_at) || c >= done_c + hold) req[d] = 1'b0;
                if (c >= done_c && req[d] == 1'b0) released = 1'b1;
            end
        end
        chk($sformatf("txn_end d%0d a=%0h", d, a), 128'(finished), 128'(1'b1));
    endtask

    initial begin
        logic [31:0] a;
        int          l;
        n_cmp  = 0;
        n_fail = 0;
        for (int d = 0; d < 2; d++) begin
            req[d] = 1'b0; adr[d] = '0; rdwr[d] = 1'b0; wdat[d] = '0;
            hold_dat[d] = '0; hold_word[d] = '0;
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_outputs(0, "reset", 1'b0, 1'b0);
        chk_outputs(1, "reset", 1'b0, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk_outputs(0, "post_reset", 1'b0, 1'b0);

        for (int d = 0; d < 2; d++) begin
            l = lat_of(d);
            do_txn(d, 1'b1, 32'h0000_0100, 128'h33333333_22222222_11111111_00000000, 10, 0, 0);
            do_txn(d, 1'b0, 32'h0000_0108, 128'h0, 10, 0, 0);
            do_txn(d, 1'b0, 32'h0000_0108, 128'h0, 0, l, 0);
            do_txn(d, 1'b0, 32'hFFFF_F108, 128'h0, 0, 0, l + 2);
            do_txn(d, 1'b0, 32'h0000_0108, 128'h0, 2, 0, 0);
            do_txn(d, 1'b0, 32'h8000_010C, 128'h0, 0, 0, 0);
        end

        for (int i = 0; i < 8; i++) pool[i] = $urandom_range(255, 0);
        for (int d = 0; d < 2; d++) begin
            l = lat_of(d);
            for (int i = 0; i < 8; i++) begin
                a = $urandom;
                a[11:4] = 8'(pool[i]);
                do_txn(d, 1'b1, a, {$urandom, $urandom, $urandom, $urandom},
                       $urandom_range(3, 0), 0, 0);
            end
            for (int n = 0; n < 16; n++) begin
                a = $urandom;
                a[11:4] = 8'(pool[$urandom_range(7, 0)]);
                if ($urandom_range(3, 0) == 0)
                    do_txn(d, 1'b1, a, {$urandom, $urandom, $urandom, $urandom},
                           $urandom_range(3, 0), 0, 0);
                else
                    do_txn(d, 1'b0, a, 128'h0, $urandom_range(3, 0),
                           ($urandom_range(3, 0) == 0) ? $urandom_range(l + 6, 1) : 0, 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no summary expected summary before timeout");
        $fatal(1);
    end

endmodule
